// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared state encoding, port ids and counter limit for the memory port arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RDWAIT = 2'd2} state_t;
  localparam logic PORT_AXI = 1'b0;
  localparam logic PORT_MIPS = 1'b1;
  localparam logic [31:0] CNT_SAT = 32'hFFFF_FFFF;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: AXI-side, MIPS-side and memory-side signals of the shared memory port.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 13
) ();
  logic                  a_req;
  logic                  a_we;
  logic [ADDR_WIDTH-3:0] a_addr;
  logic [31:0]           a_wdata;
  logic                  a_gnt;
  logic                  a_rvalid;
  logic [31:0]           a_rdata;
  logic                  m_req;
  logic                  m_we;
  logic [ADDR_WIDTH-3:0] m_addr;
  logic [31:0]           m_wdata;
  logic                  m_gnt;
  logic                  m_rvalid;
  logic [31:0]           m_rdata;
  logic [ADDR_WIDTH-3:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_we;
  logic                  mem_re;
  logic [31:0]           mem_rdata;
  modport slave (
    input  a_req, a_we, a_addr, a_wdata, m_req, m_we, m_addr, m_wdata, mem_rdata,
    output a_gnt, a_rvalid, a_rdata, m_gnt, m_rvalid, m_rdata,
           mem_addr, mem_wdata, mem_we, mem_re
  );
  modport master (
    output a_req, a_we, a_addr, a_wdata, m_req, m_we, m_addr, m_wdata, mem_rdata,
    input  a_gnt, a_rvalid, a_rdata, m_gnt, m_rvalid, m_rdata,
           mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker; bit 0 is the AXI port, bit 1 the MIPS port.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       win,
  output logic       any
);
  assign any = |req;
  assign win = &req ? ~last : req[1];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises AXI and MIPS accesses onto one memory port with round-robin
// fairness, masks MIPS while mips_rst is high and counts contention cycles.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 13
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic              mips_rst,
  mem_port_arbiter_if.slave bus,
  output logic [31:0]       conflict_cnt
);
  localparam int AW = ADDR_WIDTH - 2;
  state_t state, next;
  logic a_eff, m_eff, win, any, go, last, id, we, a_rv, m_rv, sel_we;
  logic [AW-1:0] sel_addr;
  logic [31:0] sel_wdata, a_hold, m_hold;
  assign a_eff = bus.a_req;
  assign m_eff = bus.m_req & ~mips_rst;
  rr_arb2 u_rr (.req({m_eff, a_eff}), .last(last), .win(win), .any(any));
  assign sel_we    = win ? bus.m_we    : bus.a_we;
  assign sel_addr  = win ? bus.m_addr  : bus.a_addr;
  assign sel_wdata = win ? bus.m_wdata : bus.a_wdata;
  always_comb begin
    go   = 1'b0;
    next = state;
    go   = (state == IDLE) & any;
    next = state == IDLE ? (any ? ISSUE : IDLE) : (state == ISSUE && !we) ? RDWAIT : IDLE;
  end
  // Read data is only present on mem_rdata during RDWAIT, so it is passed through that cycle
  // and captured for holding afterwards.
  assign bus.a_rvalid = a_rv;
  assign bus.m_rvalid = m_rv;
  assign bus.a_rdata  = a_rv ? bus.mem_rdata : a_hold;
  assign bus.m_rdata  = m_rv ? bus.mem_rdata : m_hold;
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state         <= IDLE;
      last          <= PORT_MIPS;
      id            <= PORT_AXI;
      we            <= 1'b0;
      bus.a_gnt     <= 1'b0;
      bus.m_gnt     <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_re    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      a_rv          <= 1'b0;
      m_rv          <= 1'b0;
      a_hold        <= '0;
      m_hold        <= '0;
      conflict_cnt  <= '0;
    end else begin
      state         <= next;
      if (go) begin
        last <= win;
        id   <= win;
        we   <= sel_we;
      end
      bus.a_gnt     <= go & (win == PORT_AXI);
      bus.m_gnt     <= go & (win == PORT_MIPS);
      bus.mem_we    <= go & sel_we;
      bus.mem_re    <= go & ~sel_we;
      bus.mem_addr  <= go ? sel_addr : '0;
      bus.mem_wdata <= go ? sel_wdata : '0;
      a_rv          <= (state == ISSUE) & ~we & (id == PORT_AXI);
      m_rv          <= (state == ISSUE) & ~we & (id == PORT_MIPS);
      if (a_rv) a_hold <= bus.mem_rdata;
      if (m_rv) m_hold <= bus.mem_rdata;
      if (a_eff && m_eff && conflict_cnt != CNT_SAT) conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
endmodule
